// File: rtl/sram_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_2x1
// Purpose  : Shares one synchronous SRAM port (1-cycle read latency) between
//            an instruction master (m0) and a data master (m1). Arbitration
//            is round-robin by default; defining SRAM_ARB_DATA_PRIO_EN gives
//            m1 fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter_2x1 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_en,
  input  logic [DW/8-1:0]   m0_wen,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DW-1:0]     m0_rdata,
  input  logic              m1_en,
  input  logic [DW/8-1:0]   m1_wen,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DW-1:0]     m1_rdata,
  output logic              s_en,
  output logic [DW/8-1:0]   s_wen,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_wdata,
  input  logic [DW-1:0]     s_rdata
);

  localparam int c_BW = DW / 8;

  logic            w_m0_gnt;
  logic            w_m1_gnt;
  logic            w_any_gnt;
  logic            w_m0_rvalid;
  logic            w_m1_rvalid;

  logic            rd_pend_q,  rd_pend_d;
  logic            rd_owner_q, rd_owner_d;
  logic [DW-1:0]   hold0_q,    hold0_d;
  logic [DW-1:0]   hold1_q,    hold1_d;

`ifdef SRAM_ARB_DATA_PRIO_EN
  always_comb begin
    w_m1_gnt = reset & m1_en;
    w_m0_gnt = reset & m0_en & ~m1_en;
  end
`else
  logic            last_gnt_q, last_gnt_d;

  // On a conflict the master that was not granted last wins.
  always_comb begin
    w_m0_gnt = reset & m0_en & (~m1_en | last_gnt_q);
    w_m1_gnt = reset & m1_en & (~m0_en | ~last_gnt_q);
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (w_m0_gnt)      last_gnt_d = 1'b0;
    else if (w_m1_gnt) last_gnt_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) last_gnt_q <= 1'b1;
    else        last_gnt_q <= last_gnt_d;
  end
`endif

  assign w_any_gnt = w_m0_gnt | w_m1_gnt;
  assign m0_gnt    = w_m0_gnt;
  assign m1_gnt    = w_m1_gnt;

  always_comb begin
    s_en    = w_any_gnt;
    s_wen   = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (w_m1_gnt) begin
      s_wen   = m1_wen;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end else if (w_m0_gnt) begin
      s_wen   = m0_wen;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end
  end

  // Gated by reset so a pending return is dropped the moment reset asserts.
  assign w_m0_rvalid = reset & rd_pend_q & ~rd_owner_q;
  assign w_m1_rvalid = reset & rd_pend_q &  rd_owner_q;

  assign m0_rvalid = w_m0_rvalid;
  assign m1_rvalid = w_m1_rvalid;
  assign m0_rdata  = w_m0_rvalid ? s_rdata : hold0_q;
  assign m1_rdata  = w_m1_rvalid ? s_rdata : hold1_q;

  always_comb begin
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    if (w_m1_gnt) begin
      rd_pend_d  = (m1_wen == {c_BW{1'b0}});
      rd_owner_d = 1'b1;
    end else if (w_m0_gnt) begin
      rd_pend_d  = (m0_wen == {c_BW{1'b0}});
      rd_owner_d = 1'b0;
    end
    hold0_d = w_m0_rvalid ? s_rdata : hold0_q;
    hold1_d = w_m1_rvalid ? s_rdata : hold1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      hold0_q    <= '0;
      hold1_q    <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter_2x1
// Purpose  : Directed vector bench for sram_arbiter_2x1 with a behavioural
//            byte-enabled SRAM; honours SRAM_ARB_DATA_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter_2x1;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_en, m1_en;
  logic [3:0]  m0_wen, m1_wen;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_en;
  logic [3:0]  s_wen;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_arbiter_2x1 #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_en(m0_en), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_en(m1_en), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_en(s_en), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata)
  );

  // Behavioural SRAM, 256 words, one-cycle read latency.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (s_en) begin
      if (s_wen == 4'h0) s_rdata <= mem[s_addr[9:2]];
      else begin
        for (int b = 0; b < 4; b++)
          if (s_wen[b]) mem[s_addr[9:2]][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        e0;  logic [3:0] w0;  logic [31:0] a0;  logic [31:0] d0;
    logic        e1;  logic [3:0] w1;  logic [31:0] a1;  logic [31:0] d1;
    logic        g0;  logic g1;  logic v0;  logic v1;  logic sen;
    logic [31:0] sa;  logic [31:0] sw;  logic [31:0] r0;  logic [31:0] r1;
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];

  task automatic set_in(input int i, input logic rst,
                        input logic e0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic e1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1);
    tv[i].rst = rst;
    tv[i].e0 = e0; tv[i].w0 = w0; tv[i].a0 = a0; tv[i].d0 = d0;
    tv[i].e1 = e1; tv[i].w1 = w1; tv[i].a1 = a1; tv[i].d1 = d1;
  endtask

  task automatic set_ex(input int i, input logic g0, input logic g1, input logic v0,
                        input logic v1, input logic sen, input logic [31:0] sa,
                        input logic [31:0] sw, input logic [31:0] r0, input logic [31:0] r1);
    tv[i].g0 = g0; tv[i].g1 = g1; tv[i].v0 = v0; tv[i].v1 = v1; tv[i].sen = sen;
    tv[i].sa = sa; tv[i].sw = sw; tv[i].r0 = r0; tv[i].r1 = r1;
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    m0_en = v.e0; m0_wen = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_en = v.e1; m1_wen = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]          = 32'h1111_1111;
    mem[1]          = 32'h2222_2222;
    mem[3]          = 32'hFFFF_FFFF;
    mem[32'h100>>2] = 32'hDEAD_BEEF;

    // Reset held with both masters requesting.
    for (int i = 0; i < 3; i++) begin
      set_in(i, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0);
      set_ex(i, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    end
    // Continuous reads from both masters: grants alternate m0, m1.
    for (int i = 3; i < 7; i++)
      set_in(i, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0);
    set_ex(3, 1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0,         32'h0);
    set_ex(4, 0, 1, 1, 0, 1, 32'h4, 32'h0, 32'h1111_1111, 32'h0);
    set_ex(5, 1, 0, 0, 1, 1, 32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222);
    set_ex(6, 0, 1, 1, 0, 1, 32'h4, 32'h0, 32'h1111_1111, 32'h2222_2222);
    // Lone m0 read of 0x100, then the hold register keeps the word.
    set_in(7, 1'b1, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_ex(7, 1, 0, 0, 1, 1, 32'h100, 32'h0, 32'h1111_1111, 32'h2222_2222);
    set_in(8, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_ex(8, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h2222_2222);
    set_in(9, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_ex(9, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h2222_2222);
    // Full write by m1, read back by m0.
    set_in(10, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h8, 32'h1234_5678);
    set_ex(10, 0, 1, 0, 0, 1, 32'h8, 32'h1234_5678, 32'hDEAD_BEEF, 32'h2222_2222);
    set_in(11, 1'b1, 1'b1, 4'h0, 32'h8, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_ex(11, 1, 0, 0, 0, 1, 32'h8, 32'h0, 32'hDEAD_BEEF, 32'h2222_2222);
    // Partial write by m1 over 0xFFFFFFFF, then m1 reads it back.
    set_in(12, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h3, 32'hC, 32'hAAAA_5555);
    set_ex(12, 0, 1, 1, 0, 1, 32'hC, 32'hAAAA_5555, 32'h1234_5678, 32'h2222_2222);
    set_in(13, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'hC, 32'h0);
    set_ex(13, 0, 1, 0, 0, 1, 32'hC, 32'h0, 32'h1234_5678, 32'h2222_2222);
    set_in(14, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_ex(14, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h1234_5678, 32'hFFFF_5555);
    // m0 read granted, reset the next cycle: the return must vanish.
    set_in(15, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_ex(15, 1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h1234_5678, 32'hFFFF_5555);
    set_in(16, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_ex(16, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h1234_5678, 32'hFFFF_5555);
    set_in(17, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_ex(17, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    // First conflict after reset.
    set_in(18, 1'b1, 1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 4'h0, 32'h14, 32'h0);
`ifdef SRAM_ARB_DATA_PRIO_EN
    set_ex(18, 0, 1, 0, 0, 1, 32'h14, 32'h0, 32'h0, 32'h0);
`else
    set_ex(18, 1, 0, 0, 0, 1, 32'h10, 32'h0, 32'h0, 32'h0);
`endif

    drive(tv[0]);
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(tv[i]);
      @(negedge clk);
      check("m0_gnt",    i, {31'h0, m0_gnt},    {31'h0, tv[i].g0});
      check("m1_gnt",    i, {31'h0, m1_gnt},    {31'h0, tv[i].g1});
      check("m0_rvalid", i, {31'h0, m0_rvalid}, {31'h0, tv[i].v0});
      check("m1_rvalid", i, {31'h0, m1_rvalid}, {31'h0, tv[i].v1});
      check("s_en",      i, {31'h0, s_en},      {31'h0, tv[i].sen});
      check("s_addr",    i, s_addr,             tv[i].sa);
      check("s_wdata",   i, s_wdata,            tv[i].sw);
      check("m0_rdata",  i, m0_rdata,           tv[i].r0);
      check("m1_rdata",  i, m1_rdata,           tv[i].r1);
      if (!tv[i].sen) check("s_wen_idle", i, {28'h0, s_wen}, 32'h0);
    end

    // Sustained conflict: alternation in round-robin, m1 always with priority.
    for (int k = 0; k < 4; k++) begin
      logic exp1;
`ifdef SRAM_ARB_DATA_PRIO_EN
      exp1 = 1'b1;
`else
      exp1 = (k % 2 == 0);
`endif
      @(posedge clk); #1;
      @(negedge clk);
      check("conflict_m1_gnt", 100 + k, {31'h0, m1_gnt}, {31'h0, exp1});
      check("conflict_m0_gnt", 100 + k, {31'h0, m0_gnt}, {31'h0, ~exp1});
      check("conflict_s_en",   100 + k, {31'h0, s_en},   32'h1);
    end

    @(posedge clk); #1;
    m0_en = 1'b0; m1_en = 1'b0;
    @(negedge clk);
    check("idle_s_en",   200, {31'h0, s_en}, 32'h0);
    check("idle_s_addr", 200, s_addr,        32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_arbiter_2x1.md
Name: sram_arbiter_2x1

Overview:
- Two-master, one-slave arbiter that shares a single synchronous SRAM port (1-cycle read latency) between the instruction-fetch master (m0) and the data master (m1).
- Used to build a unified instruction/data memory.
- Sits between cpu_pipeline and one sram instance.
- Schedules accesses cycle by cycle and routes each read return to the master that issued it.

Parameters:
- AW, 32, address width of the master and slave ports.
- DW, 32, data width. Byte-enable width is DW/8.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- m0_en  in  1  master 0 request.
- m0_wen  in  DW/8  master 0 byte write enables; 0 means read.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_gnt  out  1  master 0 request accepted this cycle.
- m0_rvalid  out  1  master 0 read data valid (1-cycle pulse).
- m0_rdata  out  DW  master 0 read data.
- m1_en, m1_wen, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for master 1.
- s_en  out  1  SRAM enable.
- s_wen  out  DW/8  SRAM byte write enables.
- s_addr  out  AW  SRAM address, passed unsliced.
- s_wdata  out  DW  SRAM write data.
- s_rdata  in  DW  SRAM read data, valid the cycle after the read.

Behaviour:

Handshake
- A master holds en, wen, addr and wdata stable until it sees gnt=1 in the same cycle.
- The request transfers on the clock edge where en and gnt are both 1.
- gnt is combinational from en and the arbiter state; an uncontended request has zero wait cycles.

Arbitration (round-robin)
- Register last_gnt (1 bit) records the last master granted.
- Only one en high: that master is granted.
- Both en high: the master other than last_gnt is granted; the loser keeps waiting.
- last_gnt updates on every grant.
- At most one gnt is high per cycle.

Slave drive
- s_en = m0_gnt | m1_gnt.
- s_wen, s_addr and s_wdata are muxed from the granted master.
- When no master is granted: s_en=0 and s_wen=0. s_addr and s_wdata are don't-care, but must be held at zero.

Read return
- A granted read (wen==0) sets rd_pend<=1 and rd_owner<=id.
- The next cycle, the owner's rvalid=1 and its rdata=s_rdata. The same value is captured into that master's hold register.
- In every other cycle, mX_rdata is that master's hold register, which stays stable until its next read returns.
- A granted write sets rd_pend<=0 and produces no rvalid.
- Back-to-back reads are fully pipelined:
  - cycle n: grant m0 read.
  - cycle n+1: m0_rvalid=1 and grant m1 read.
  - cycle n+2: m1_rvalid=1.
- Sustained throughput is one access per cycle.

Reset (reset==0 at a clock edge)
- last_gnt<=1, so m0 wins the first conflict.
- rd_pend<=0, rd_owner<=0, both hold registers <=0.
- While reset==0: m0_gnt=m1_gnt=0, s_en=0, s_wen=0, rvalid=0.
- Reset mid-operation discards any pending read return; no rvalid follows reset.

Boundaries
- A master deasserting en before it is granted is illegal and not checked.
- Read and write hazards between masters are resolved purely by grant order, since the SRAM is single-port.

Optional Feature:
- Macro SRAM_ARB_DATA_PRIO_EN.
- Defined: fixed priority, m1 (data) always wins a conflict and last_gnt is unused. m0 can starve while m1 requests every cycle; this is accepted for load/store latency.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset low 3 cycles with m0_en=m1_en=1: both gnt=0, s_en=0, rvalid=0. After release, first conflict grants m0.
2. m0 read alone, addr=0x100, SRAM word 0x100 = 0xDEADBEEF: m0_gnt=1 same cycle; next cycle m0_rvalid=1 and m0_rdata=0xDEADBEEF; m0_rdata holds 0xDEADBEEF afterwards.
3. Both masters continuously reading, m0 addr=0x0 and m1 addr=0x4: grants alternate m0,m1,m0,m1; each rvalid arrives exactly one cycle after its grant with the correct word; s_en=1 every cycle.
4. m1 write, wen=0xF, addr=0x8, data=0x12345678, then m0 read addr=0x8: write granted with no rvalid; m0 read returns 0x12345678.
5. m1 partial write wen=0x3 data=0xAAAA5555 over 0xFFFFFFFF, then read: returns 0xFFFF5555.
6. m0 read granted, then reset asserted the next cycle: no m0_rvalid, hold register=0. With SRAM_ARB_DATA_PRIO_EN, both masters requesting: m1 granted every cycle, m0_gnt stays 0.
